// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two valid/ready requesters, driving the ALU from registers.
// Define ALU_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 always wins ties.
module alu_arbiter #(
   parameter int DW  = 8,
   parameter int OPW = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0_valid,
   input  logic            req1_valid,
   output logic            req0_ready,
   output logic            req1_ready,
   input  logic [DW-1:0]   req0_a,
   input  logic [DW-1:0]   req0_b,
   input  logic [DW-1:0]   req1_a,
   input  logic [DW-1:0]   req1_b,
   input  logic [OPW-1:0]  req0_op,
   input  logic [OPW-1:0]  req1_op,
   output logic            rsp0_valid,
   output logic            rsp1_valid,
   input  logic            rsp0_ready,
   input  logic            rsp1_ready,
   output logic [DW-1:0]   rsp_result,
   output logic [2*DW-1:0] rsp_mulresult,
   output logic            rsp_carry,
   output logic            rsp_zero,
   output logic [DW-1:0]   alu_a,
   output logic [DW-1:0]   alu_b,
   output logic [OPW-1:0]  alu_opcode,
   input  logic [DW-1:0]   alu_result,
   input  logic [2*DW-1:0] alu_mulresult,
   input  logic            alu_carry,
   input  logic            alu_zero,
   output logic            busy,
   output logic            grant_id
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t            state_q, state_d;
   logic [DW-1:0]     a_q, a_d, b_q, b_d;
   logic [OPW-1:0]    op_q, op_d;
   logic              grant_q, grant_d;
   logic [DW-1:0]     res_q, res_d;
   logic [2*DW-1:0]   mul_q, mul_d;
   logic              carry_q, carry_d;
   logic              zero_q, zero_d;
   logic              win1;
   logic              rspDone;

   assign rspDone = (state_q == RESP) && (grant_q ? rsp1_ready : rsp0_ready);

`ifdef ALU_ARB_RR_EN
   logic last_q, last_d;

   // On a tie the port that was not served last wins.
   assign win1 = req1_valid && (!req0_valid || !last_q);

   always_comb begin
      last_d = last_q;
      if (rspDone) last_d = grant_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_q <= 1'b1;
      else     last_q <= last_d;
   end
`else
   assign win1 = req1_valid && !req0_valid;
`endif

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      grant_d    = grant_q;
      res_d      = res_q;
      mul_d      = mul_q;
      carry_d    = carry_q;
      zero_d     = zero_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0_valid || req1_valid) begin
               req0_ready = !win1;
               req1_ready = win1;
               grant_d    = win1;
               a_d        = win1 ? req1_a  : req0_a;
               b_d        = win1 ? req1_b  : req0_b;
               op_d       = win1 ? req1_op : req0_op;
               state_d    = EXEC;
            end
         end
         EXEC: begin
            res_d   = alu_result;
            mul_d   = alu_mulresult;
            carry_d = alu_carry;
            zero_d  = alu_zero;
            state_d = RESP;
         end
         RESP: begin
            rsp0_valid = !grant_q;
            rsp1_valid = grant_q;
            if (rspDone) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         grant_q <= 1'b0;
         res_q   <= '0;
         mul_q   <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         grant_q <= grant_d;
         res_q   <= res_d;
         mul_q   <= mul_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
      end
   end

   assign alu_a         = a_q;
   assign alu_b         = b_q;
   assign alu_opcode    = op_q;
   assign rsp_result    = res_q;
   assign rsp_mulresult = mul_q;
   assign rsp_carry     = carry_q;
   assign rsp_zero      = zero_q;
   assign busy          = (state_q != IDLE);
   assign grant_id      = grant_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: drives alu_arbiter with a stub adder/multiplier ALU and checks every cycle against a transaction-level model.
module tb_alu_arbiter;

   localparam int DW  = 8;
   localparam int OPW = 3;

   logic            clk;
   logic            rst;
   logic            req0_valid, req1_valid, req0_ready, req1_ready;
   logic [DW-1:0]   req0_a, req0_b, req1_a, req1_b;
   logic [OPW-1:0]  req0_op, req1_op;
   logic            rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
   logic [DW-1:0]   rsp_result;
   logic [2*DW-1:0] rsp_mulresult;
   logic            rsp_carry, rsp_zero;
   logic [DW-1:0]   alu_a, alu_b;
   logic [OPW-1:0]  alu_opcode;
   logic [DW-1:0]   alu_result;
   logic [2*DW-1:0] alu_mulresult;
   logic            alu_carry, alu_zero;
   logic            busy, grant_id;
   logic [DW:0]     aluSum;

   alu_arbiter #(.DW(DW), .OPW(OPW)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .req0_op(req0_op), .req1_op(req1_op),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
      .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result), .rsp_mulresult(rsp_mulresult),
      .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_result(alu_result), .alu_mulresult(alu_mulresult),
      .alu_carry(alu_carry), .alu_zero(alu_zero),
      .busy(busy), .grant_id(grant_id)
   );

   // Stub ALU: 9-bit add for result/carry, full-width multiply.
   assign aluSum        = {1'b0, alu_a} + {1'b0, alu_b};
   assign alu_result    = aluSum[DW-1:0];
   assign alu_carry     = aluSum[DW];
   assign alu_zero      = (aluSum[DW-1:0] == '0);
   assign alu_mulresult = {8'b0, alu_a} * {8'b0, alu_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int compareCount = 0;
   int mismatchCount = 0;

   // Requester-side state: one held request per port.
   bit   pend[2];
   int   reqA[2], reqB[2], reqOp[2];
   bit   rspRdy[2];
   int   opsLeft[2];
   int   dutOrder[$];

   // Transaction-level model.
   bit   mBusy;
   bit   mCaptured;
   int   mOwner, mLast;
   int   mA, mB, mOp;
   int   mRes, mMul, mCarry, mZero;
   int   lastAccept;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      mBusy = 0; mCaptured = 0; mOwner = 0; mLast = 1;
      mA = 0; mB = 0; mOp = 0;
      mRes = 0; mMul = 0; mCarry = 0; mZero = 0;
      lastAccept = -1;
   endtask

   function automatic int expWinner();
      if (mBusy) return -1;
      if (pend[0] && pend[1]) begin
`ifdef ALU_ARB_RR_EN
         return (mLast == 1) ? 0 : 1;
`else
         return 0;
`endif
      end
      if (pend[0]) return 0;
      if (pend[1]) return 1;
      return -1;
   endfunction

   task automatic applyStimulus();
      req0_valid = pend[0]; req0_a = reqA[0][7:0]; req0_b = reqB[0][7:0]; req0_op = reqOp[0][2:0];
      req1_valid = pend[1]; req1_a = reqA[1][7:0]; req1_b = reqB[1][7:0]; req1_op = reqOp[1][2:0];
      rsp0_ready = rspRdy[0];
      rsp1_ready = rspRdy[1];
   endtask

   task automatic newRequest(input int p, input int a, input int b, input int op);
      pend[p] = 1; reqA[p] = a; reqB[p] = b; reqOp[p] = op;
   endtask

   function automatic int pickOperand();
      case ($urandom_range(5))
         0:       return 0;
         1:       return 255;
         default: return int'($urandom_range(255));
      endcase
   endfunction

   // One clock: check the model against the DUT mid-cycle, then advance the model at the edge.
   task automatic stepCycle();
      int w;
      @(negedge clk);
      w = expWinner();
      checkOutput("req0_ready", req0_ready, (w == 0));
      checkOutput("req1_ready", req1_ready, (w == 1));
      checkOutput("rsp0_valid", rsp0_valid, (mBusy && mCaptured && mOwner == 0));
      checkOutput("rsp1_valid", rsp1_valid, (mBusy && mCaptured && mOwner == 1));
      checkOutput("busy", busy, mBusy);
      checkOutput("grant_id", grant_id, mOwner);
      checkOutput("alu_a", alu_a, mA);
      checkOutput("alu_b", alu_b, mB);
      checkOutput("alu_opcode", alu_opcode, mOp);
      checkOutput("rsp_result", rsp_result, mRes);
      checkOutput("rsp_mulresult", rsp_mulresult, mMul);
      checkOutput("rsp_carry", rsp_carry, mCarry);
      checkOutput("rsp_zero", rsp_zero, mZero);
      if (req0_ready) dutOrder.push_back(0);
      if (req1_ready) dutOrder.push_back(1);
      @(posedge clk);
      lastAccept = -1;
      if (!mBusy) begin
         if (w >= 0) begin
            mBusy = 1; mCaptured = 0; mOwner = w; lastAccept = w;
            mA = reqA[w]; mB = reqB[w]; mOp = reqOp[w];
         end
      end else if (!mCaptured) begin
         mRes   = (mA + mB) % 256;
         mCarry = (mA + mB) / 256;
         mZero  = (mRes == 0);
         mMul   = mA * mB;
         mCaptured = 1;
      end else if (rspRdy[mOwner]) begin
         mLast = mOwner;
         mBusy = 0;
      end
      #1;
   endtask

   // mode 0: manual, 1: burst until opsLeft exhausted, 2: random traffic.
   task automatic stepAndDrive(input int mode);
      stepCycle();
      for (int p = 0; p < 2; p++) begin
         if (lastAccept == p) begin
            pend[p] = 0;
            if (opsLeft[p] > 0) opsLeft[p]--;
         end
         if (mode == 1 && !pend[p] && opsLeft[p] > 0)
            newRequest(p, pickOperand(), pickOperand(), int'($urandom_range(7)));
         if (mode == 2) begin
            if (pend[p] && $urandom_range(15) == 0) pend[p] = 0;
            if (!pend[p] && $urandom_range(2) == 0)
               newRequest(p, pickOperand(), pickOperand(), int'($urandom_range(7)));
            rspRdy[p] = ($urandom_range(3) != 0);
         end
      end
      applyStimulus();
   endtask

   initial begin
      int guard;
      int expOrder[8];
      for (int p = 0; p < 2; p++) begin
         pend[p] = 0; reqA[p] = 0; reqB[p] = 0; reqOp[p] = 0; rspRdy[p] = 1; opsLeft[p] = 0;
      end
      applyStimulus();
      rst = 1'b1;
      modelReset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      checkOutput("reset busy", busy, 0);
      checkOutput("reset grant_id", grant_id, 0);
      checkOutput("reset rsp_mulresult", rsp_mulresult, 0);
      repeat (5) stepAndDrive(0);

      // Single port-0 op with latency checks.
      newRequest(0, 44, 11, 0);
      applyStimulus();
      #1 checkOutput("t2 ready0 before T", req0_ready, 1);
      stepAndDrive(0);
      checkOutput("t2 busy after T", busy, 1);
      checkOutput("t2 rsp0_valid after T", rsp0_valid, 0);
      stepAndDrive(0);
      checkOutput("t2 rsp0_valid after T+1", rsp0_valid, 1);
      checkOutput("t2 result", rsp_result, 55);
      checkOutput("t2 mulresult", rsp_mulresult, 484);
      checkOutput("t2 carry", rsp_carry, 0);
      checkOutput("t2 zero", rsp_zero, 0);
      stepAndDrive(0);
      checkOutput("t2 busy after T+2", busy, 0);

      // Port-1 op with carry out.
      newRequest(1, 200, 100, 5);
      applyStimulus();
      repeat (2) stepAndDrive(0);
      checkOutput("t3 rsp1_valid", rsp1_valid, 1);
      checkOutput("t3 rsp0_valid", rsp0_valid, 0);
      checkOutput("t3 result", rsp_result, 44);
      checkOutput("t3 carry", rsp_carry, 1);
      checkOutput("t3 mulresult", rsp_mulresult, 20000);
      stepAndDrive(0);

      // Both ports continuously requesting, 4 ops each.
      dutOrder.delete();
      opsLeft[0] = 4; opsLeft[1] = 4;
      newRequest(0, pickOperand(), pickOperand(), 1);
      newRequest(1, pickOperand(), pickOperand(), 2);
      applyStimulus();
      guard = 0;
      while ((opsLeft[0] > 0 || opsLeft[1] > 0 || mBusy) && guard < 100) begin
         stepAndDrive(1);
         guard++;
      end
      checkOutput("burst finished in budget", (guard < 100), 1);
      checkOutput("burst grant count", dutOrder.size(), 8);
`ifdef ALU_ARB_RR_EN
      expOrder = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
      expOrder = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
      for (int i = 0; i < 8 && i < dutOrder.size(); i++)
         checkOutput($sformatf("burst grant %0d", i), dutOrder[i], expOrder[i]);

      // Backpressure on port 0 while port 1 waits.
      rspRdy[0] = 0; rspRdy[1] = 1;
      newRequest(0, 9, 7, 3);
      applyStimulus();
      stepAndDrive(0);
      newRequest(1, 3, 4, 6);
      applyStimulus();
      stepAndDrive(0);
      for (int i = 0; i < 10; i++) begin
         stepAndDrive(0);
         checkOutput("bp rsp0_valid held", rsp0_valid, 1);
         checkOutput("bp result held", rsp_result, 16);
         checkOutput("bp req1_ready low", req1_ready, 0);
      end
      rspRdy[0] = 1;
      applyStimulus();
      stepAndDrive(0);
      stepAndDrive(0);
      checkOutput("bp req1 served grant", grant_id, 1);
      checkOutput("bp req1 served busy", busy, 1);
      repeat (3) stepAndDrive(0);

      // Reset during EXEC of a port-1 op.
      newRequest(1, 77, 33, 4);
      applyStimulus();
      stepAndDrive(0);
      #2 rst = 1'b1;
      #1;
      checkOutput("rst busy", busy, 0);
      checkOutput("rst rsp1_valid", rsp1_valid, 0);
      checkOutput("rst grant_id", grant_id, 0);
      checkOutput("rst alu_a", alu_a, 0);
      checkOutput("rst rsp_result", rsp_result, 0);
      modelReset();
      pend[0] = 0; pend[1] = 0;
      applyStimulus();
      @(posedge clk);
      #1 rst = 1'b0;
      stepAndDrive(0);
      checkOutput("rst no late rsp", rsp1_valid, 0);
      dutOrder.delete();
      newRequest(0, 5, 6, 0);
      newRequest(1, 7, 8, 0);
      applyStimulus();
      stepAndDrive(0);
      checkOutput("post-reset tie winner", (dutOrder.size() > 0) ? dutOrder[0] : -1, 0);

      // Randomized traffic with random response backpressure.
      for (int i = 0; i < 600; i++) stepAndDrive(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer that shares the single combinational 8-bit ALU (A/B/opcode in; result/carry/zero/mulresult out) between two independent requesters. Each requester submits an operand pair plus opcode over a valid/ready handshake. It receives the captured ALU outputs over a response valid/ready handshake. The block sits between the requesting engines and the ALU instance and drives every ALU input from registers.

## Interface
- `DW`, 8, operand/result width; mulresult is 2*DW.
- `OPW`, 3, opcode width.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `req0_valid`, `req1_valid`  in  1  request present.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle (valid & ready).
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  DW  operands.
- `req0_op`, `req1_op`  in  OPW  opcode.
- `rsp0_valid`, `rsp1_valid`  out  1  response holding.
- `rsp0_ready`, `rsp1_ready`  in  1  response consumed.
- `rsp_result`  out  DW  captured ALU result (shared by both ports).
- `rsp_mulresult`  out  2*DW  captured ALU mulresult.
- `rsp_carry`, `rsp_zero`  out  1  captured flags.
- `alu_a`, `alu_b`  out  DW  to ALU A/B.
- `alu_opcode`  out  OPW  to ALU opcode.
- `alu_result`  in  DW; `alu_mulresult`  in  2*DW; `alu_carry`, `alu_zero`  in  1  from ALU.
- `busy`  out  1  state != IDLE.
- `grant_id`  out  1  requester owning current/last operation.

## Operation
- FSM states IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Arbitrate among asserted valids.
  - The granted port's ready is driven combinationally (state==IDLE & its valid & it wins). At most one ready is high.
  - On accept: latch a/b/op into `alu_a`/`alu_b`/`alu_opcode`, set `grant_id`, go EXEC.
  - With no valid: stay; both readies low.
- EXEC:
  - ALU inputs are stable from registers.
  - At the clock edge, capture `alu_result`/`alu_mulresult`/`alu_carry`/`alu_zero` into the `rsp_*` registers. Go RESP.
- RESP:
  - `rspN_valid` is high for N==`grant_id` only.
  - When `rspN_ready` is high at the edge: drop valid, update the round-robin pointer to `grant_id`, go IDLE.
  - Both readies stay low throughout RESP and EXEC.
- Arbitration is round-robin (see Configuration). When both valids are high, the port not granted last wins. After reset the pointer is "last=1", so port 0 wins the first tie.
- `alu_*` and `rsp_*` hold their last values outside EXEC/RESP; they are not cleared after a transaction.
- Requesters must hold valid and operands until ready. Dropping valid before acceptance withdraws the request with no side effect.
- No arithmetic is performed in this block; widths pass through unmodified.

## Timing
- Reset values: state IDLE; all ready/valid 0; `busy` 0; `grant_id` 0; `alu_a`/`alu_b`/`alu_opcode` 0; `rsp_*` 0; RR pointer 1.
- Latency: accept at edge T; response captured at T+1; `rspN_valid` is visible after T+1. When rsp_ready is already high, the response completes at T+2 and the next accept can occur at T+3. Peak throughput is 1 op per 3 cycles.
- Backpressure: RESP holds indefinitely with `rsp_*` stable.
- A new request arriving during EXEC/RESP waits; it is arbitrated in the first IDLE cycle.
- Reset mid-transaction: abort immediately, emit no response, and return to reset values.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration as above.
- `ALU_ARB_RR_EN` undefined: fixed priority, port 0 always wins ties. The RR pointer is not implemented. All other behaviour is identical.

## Test plan
Bench uses a stub ALU: result=(A+B)[7:0], carry=(A+B)[8], zero=(result==0), mulresult=A*B.
- Reset, then idle 5 cycles -> all outputs 0, `busy`=0.
- req0 A=44 B=11 op=0, rsp0_ready=1 -> ready0 at T; rsp0_valid at T+1; result=55, mulresult=484, carry=0, zero=0; `busy` low at T+2.
- req1 A=200 B=100 -> result=44, carry=1, mulresult=20000; rsp1_valid only.
- Both valid continuously, each 4 ops, rsp_ready=1 -> grants 0,1,0,1,... with RR. Without `ALU_ARB_RR_EN`, all port-0 ops complete first.
- rsp0_ready held low 10 cycles -> rsp0_valid and result stable; ready1 stays low despite req1_valid; req1 is served after release.
- Assert `rst` during EXEC -> no rsp valid; outputs return to reset values; the next request behaves as after power-up.
